// File: rtl/mem_stage.sv
// Load/store stage: issues word-aligned cache requests over req/ack, lane-aligns sub-word data, registers writeback.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of truncating them.
module mem_stage #(
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic [3:0]  ex_op,
   input  logic [31:0] ex_addr,
   input  logic [31:0] ex_wdata,
   input  logic [4:0]  ex_rd,
   input  logic [31:0] ex_result,
   output logic        stall,
   output logic        dc_req,
   output logic        dc_we,
   output logic [31:0] dc_addr,
   output logic [31:0] dc_wdata,
   output logic [3:0]  dc_wmask,
   input  logic        dc_ack,
   input  logic [31:0] dc_rdata,
   output logic        wb_valid,
   output logic        wb_we,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        dc_timeout
`ifdef MISALIGN_TRAP_EN
   ,
   output logic        misalign
`endif
);

   typedef enum logic {IDLE, WAIT} state_t;

   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LH  = 4'd2;
   localparam logic [3:0] OP_LW  = 4'd3;
   localparam logic [3:0] OP_LBU = 4'd4;
   localparam logic [3:0] OP_LHU = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_t state, next_state;

   logic          is_mem;
   logic          is_store;
   logic          mis;
   logic          go;
   logic [1:0]    lane;
   logic [3:0]    req_mask;
   logic [31:0]   req_wdata;
   logic [3:0]    op_q;
   logic [1:0]    lane_q;
   logic [4:0]    rd_q;
   logic [CW-1:0] wait_cnt;
   logic [7:0]    ld_byte;
   logic [15:0]   ld_half;
   logic [31:0]   load_data;

   // Decode; halfwords only look at a[1] and words always use lane 0, so low bits are ignored unless trapped.
   always_comb begin
      is_mem   = (ex_op != 4'd0) && (ex_op <= OP_SW);
      is_store = (ex_op >= OP_SB) && (ex_op <= OP_SW);
      lane     = 2'b00;
      mis      = 1'b0;
      case (ex_op)
         OP_LB, OP_LBU, OP_SB: lane = ex_addr[1:0];
         OP_LH, OP_LHU, OP_SH: lane = {ex_addr[1], 1'b0};
         default:              lane = 2'b00;
      endcase
`ifdef MISALIGN_TRAP_EN
      case (ex_op)
         OP_LH, OP_LHU, OP_SH: mis = ex_addr[0];
         OP_LW, OP_SW:         mis = |ex_addr[1:0];
         default:              mis = 1'b0;
      endcase
`endif
      go = ex_valid & is_mem & ~mis;
   end

   // Store lanes are big-endian: lane 0 is bits [31:24].
   always_comb begin
      req_mask  = 4'b0000;
      req_wdata = 32'h0;
      case (ex_op)
         OP_SB: begin
            req_mask = 4'b1000 >> lane;
            case (lane)
               2'd0:    req_wdata = {ex_wdata[7:0], 24'h0};
               2'd1:    req_wdata = {8'h0, ex_wdata[7:0], 16'h0};
               2'd2:    req_wdata = {16'h0, ex_wdata[7:0], 8'h0};
               default: req_wdata = {24'h0, ex_wdata[7:0]};
            endcase
         end
         OP_SH: begin
            req_mask  = lane[1] ? 4'b0011 : 4'b1100;
            req_wdata = lane[1] ? {16'h0, ex_wdata[15:0]} : {ex_wdata[15:0], 16'h0};
         end
         OP_SW: begin
            req_mask  = 4'b1111;
            req_wdata = ex_wdata;
         end
         default: begin
            req_mask  = 4'b0000;
            req_wdata = 32'h0;
         end
      endcase
   end

   always_comb begin
      case (lane_q)
         2'd0:    ld_byte = dc_rdata[31:24];
         2'd1:    ld_byte = dc_rdata[23:16];
         2'd2:    ld_byte = dc_rdata[15:8];
         default: ld_byte = dc_rdata[7:0];
      endcase
      ld_half = lane_q[1] ? dc_rdata[15:0] : dc_rdata[31:16];
      case (op_q)
         OP_LB:   load_data = {{24{ld_byte[7]}}, ld_byte};
         OP_LBU:  load_data = {24'h0, ld_byte};
         OP_LH:   load_data = {{16{ld_half[15]}}, ld_half};
         OP_LHU:  load_data = {16'h0, ld_half};
         default: load_data = dc_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (go) next_state = WAIT;
         WAIT:    if (dc_ack) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      stall = 1'b0;
      if (!rst) begin
         case (state)
            IDLE:    stall = go;
            WAIT:    stall = ~dc_ack;
            default: stall = 1'b0;
         endcase
      end
   end

   // Request is captured once on entry to WAIT and held until the ack edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         dc_req   <= 1'b0;
         dc_we    <= 1'b0;
         dc_addr  <= 32'h0;
         dc_wdata <= 32'h0;
         dc_wmask <= 4'b0000;
         op_q     <= 4'd0;
         lane_q   <= 2'd0;
         rd_q     <= 5'd0;
      end else if (state == IDLE && go) begin
         dc_req   <= 1'b1;
         dc_we    <= is_store;
         dc_addr  <= {ex_addr[31:2], 2'b00};
         dc_wdata <= req_wdata;
         dc_wmask <= req_mask;
         op_q     <= ex_op;
         lane_q   <= lane;
         rd_q     <= ex_rd;
      end else if (state == WAIT && dc_ack) begin
         dc_req <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_valid <= 1'b0;
         wb_we    <= 1'b0;
         wb_rd    <= 5'd0;
         wb_data  <= 32'h0;
      end else begin
         wb_valid <= 1'b0;
         wb_we    <= 1'b0;
         if (state == IDLE && ex_valid && !is_mem) begin
            wb_valid <= 1'b1;
            wb_we    <= (ex_rd != 5'd0);
            wb_rd    <= ex_rd;
            wb_data  <= ex_result;
         end else if (state == WAIT && dc_ack) begin
            wb_valid <= 1'b1;
            wb_we    <= ~dc_we & (rd_q != 5'd0);
            wb_rd    <= rd_q;
            wb_data  <= dc_we ? 32'h0 : load_data;
         end
      end
   end

   // The counter saturates; the flag is sticky and only reset clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt   <= '0;
         dc_timeout <= 1'b0;
      end else if (state == IDLE && go) begin
         wait_cnt <= '0;
      end else if (state == WAIT && !dc_ack) begin
         if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + 1'b1;
         if (wait_cnt == CNT_LAST) dc_timeout <= 1'b1;
      end
   end

`ifdef MISALIGN_TRAP_EN
   always_ff @(posedge clk) begin
      if (rst) misalign <= 1'b0;
      else     misalign <= (state == IDLE) & ex_valid & is_mem & mis;
   end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: reset, pass-through, loads, stores, back-to-back, timeout, misalign.
module tb_mem_stage;

   localparam int TO = 64;

   logic        clk;
   logic        rst;
   logic        ex_valid;
   logic [3:0]  ex_op;
   logic [31:0] ex_addr;
   logic [31:0] ex_wdata;
   logic [4:0]  ex_rd;
   logic [31:0] ex_result;
   logic        stall;
   logic        dc_req;
   logic        dc_we;
   logic [31:0] dc_addr;
   logic [31:0] dc_wdata;
   logic [3:0]  dc_wmask;
   logic        dc_ack;
   logic [31:0] dc_rdata;
   logic        wb_valid;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        dc_timeout;
`ifdef MISALIGN_TRAP_EN
   logic        misalign;
`endif

   int tests;
   int failures;

   mem_stage #(.TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .ex_valid   (ex_valid),
      .ex_op      (ex_op),
      .ex_addr    (ex_addr),
      .ex_wdata   (ex_wdata),
      .ex_rd      (ex_rd),
      .ex_result  (ex_result),
      .stall      (stall),
      .dc_req     (dc_req),
      .dc_we      (dc_we),
      .dc_addr    (dc_addr),
      .dc_wdata   (dc_wdata),
      .dc_wmask   (dc_wmask),
      .dc_ack     (dc_ack),
      .dc_rdata   (dc_rdata),
      .wb_valid   (wb_valid),
      .wb_we      (wb_we),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data),
      .dc_timeout (dc_timeout)
`ifdef MISALIGN_TRAP_EN
      ,
      .misalign   (misalign)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failures++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] result);
      ex_valid  = v;
      ex_op     = op;
      ex_addr   = addr;
      ex_wdata  = wdata;
      ex_rd     = rd;
      ex_result = result;
   endtask

   // Present a memory op and step into WAIT.
   task automatic startOp(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
      applyStimulus(1'b1, op, addr, wdata, rd, 32'h0);
      #1;
      checkOutput("issue_stall", 32'(stall), 32'd1);
      tick();
   endtask

   // Acknowledge in the current WAIT cycle, step past the ack edge and retire the instruction.
   task automatic finishOp(input logic [31:0] rdata);
      dc_ack   = 1'b1;
      dc_rdata = rdata;
      #1;
      checkOutput("ack_stall", 32'(stall), 32'd0);
      tick();
      dc_ack   = 1'b0;
      ex_valid = 1'b0;
   endtask

   initial begin
      tests    = 0;
      failures = 0;
      rst      = 1'b1;
      dc_ack   = 1'b0;
      dc_rdata = 32'h0;
      applyStimulus(1'b1, 4'd3, 32'h100, 32'h0, 5'd1, 32'h0);

      #1;
      checkOutput("rst_stall", 32'(stall), 32'd0);
      tick();
      checkOutput("rst_req", 32'(dc_req), 32'd0);
      checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
      checkOutput("rst_timeout", 32'(dc_timeout), 32'd0);
      tick();
      checkOutput("rst_req_held", 32'(dc_req), 32'd0);
      rst = 1'b0;

      applyStimulus(1'b1, 4'd0, 32'h100, 32'h0, 5'd5, 32'h0000_1234);
      #1;
      checkOutput("alu_stall", 32'(stall), 32'd0);
      tick();
      checkOutput("alu_wb_valid", 32'(wb_valid), 32'd1);
      checkOutput("alu_wb_we", 32'(wb_we), 32'd1);
      checkOutput("alu_wb_rd", 32'(wb_rd), 32'd5);
      checkOutput("alu_wb_data", wb_data, 32'h0000_1234);
      checkOutput("alu_req", 32'(dc_req), 32'd0);

      applyStimulus(1'b1, 4'd12, 32'h100, 32'h0, 5'd0, 32'h0000_AAAA);
      tick();
      checkOutput("op12_wb_valid", 32'(wb_valid), 32'd1);
      checkOutput("op12_wb_we", 32'(wb_we), 32'd0);
      checkOutput("op12_wb_data", wb_data, 32'h0000_AAAA);
      checkOutput("op12_req", 32'(dc_req), 32'd0);

      // LW with ack arriving three cycles after the request: four stall cycles total.
      startOp(4'd3, 32'h100, 32'h0, 5'd7);
      checkOutput("lw_req", 32'(dc_req), 32'd1);
      checkOutput("lw_we", 32'(dc_we), 32'd0);
      checkOutput("lw_addr", dc_addr, 32'h100);
      checkOutput("lw_stall_c1", 32'(stall), 32'd1);
      checkOutput("lw_wb_idle", 32'(wb_valid), 32'd0);
      for (int i = 0; i < 2; i++) begin
         tick();
         checkOutput("lw_stall_wait", 32'(stall), 32'd1);
         checkOutput("lw_req_wait", 32'(dc_req), 32'd1);
      end
      tick();
      finishOp(32'hDEAD_BEEF);
      checkOutput("lw_wb_valid", 32'(wb_valid), 32'd1);
      checkOutput("lw_wb_data", wb_data, 32'hDEAD_BEEF);
      checkOutput("lw_wb_rd", 32'(wb_rd), 32'd7);
      checkOutput("lw_wb_we", 32'(wb_we), 32'd1);
      checkOutput("lw_req_drop", 32'(dc_req), 32'd0);

      startOp(4'd1, 32'h103, 32'h0, 5'd3);
      checkOutput("lb_addr", dc_addr, 32'h100);
      finishOp(32'h1122_33F0);
      checkOutput("lb_data", wb_data, 32'hFFFF_FFF0);

      startOp(4'd4, 32'h103, 32'h0, 5'd3);
      finishOp(32'h1122_33F0);
      checkOutput("lbu_data", wb_data, 32'h0000_00F0);

      startOp(4'd2, 32'h100, 32'h0, 5'd3);
      finishOp(32'h8001_7FFF);
      checkOutput("lh_data", wb_data, 32'hFFFF_8001);

      startOp(4'd1, 32'h101, 32'h0, 5'd0);
      finishOp(32'h007E_0000);
      checkOutput("lb1_data", wb_data, 32'h0000_007E);
      checkOutput("lb1_wb_we_r0", 32'(wb_we), 32'd0);

      startOp(4'd7, 32'h102, 32'h0000_ABCD, 5'd9);
      checkOutput("sh_we", 32'(dc_we), 32'd1);
      checkOutput("sh_addr", dc_addr, 32'h100);
      checkOutput("sh_mask", 32'(dc_wmask), 32'h3);
      checkOutput("sh_wdata", 32'(dc_wdata[15:0]), 32'h0000_ABCD);
      finishOp(32'h0);
      checkOutput("sh_wb_valid", 32'(wb_valid), 32'd1);
      checkOutput("sh_wb_we", 32'(wb_we), 32'd0);

      startOp(4'd6, 32'h101, 32'h0000_0055, 5'd9);
      checkOutput("sb_mask", 32'(dc_wmask), 32'h4);
      checkOutput("sb_wdata", 32'(dc_wdata[23:16]), 32'h55);
      finishOp(32'h0);

      startOp(4'd8, 32'h108, 32'hCAFE_F00D, 5'd9);
      checkOutput("sw_addr", dc_addr, 32'h108);
      checkOutput("sw_mask", 32'(dc_wmask), 32'hF);
      checkOutput("sw_wdata", dc_wdata, 32'hCAFE_F00D);
      finishOp(32'h0);

      // Back-to-back: the next op is already presented on the ack edge and sits one IDLE cycle.
      startOp(4'd3, 32'h10C, 32'h0, 5'd2);
      dc_ack   = 1'b1;
      dc_rdata = 32'h1111_1111;
      tick();
      dc_ack = 1'b0;
      applyStimulus(1'b1, 4'd5, 32'h102, 32'h0, 5'd6, 32'h0);
      #1;
      checkOutput("b2b_wb_data", wb_data, 32'h1111_1111);
      checkOutput("b2b_idle_req", 32'(dc_req), 32'd0);
      checkOutput("b2b_idle_stall", 32'(stall), 32'd1);
      tick();
      checkOutput("b2b_req", 32'(dc_req), 32'd1);
      finishOp(32'h8001_7FFF);
      checkOutput("lhu_data", wb_data, 32'h0000_7FFF);

      dc_ack = 1'b1;
      tick();
      dc_ack = 1'b0;
      checkOutput("idle_ack_wb", 32'(wb_valid), 32'd0);
      checkOutput("idle_ack_req", 32'(dc_req), 32'd0);

      // Reset in WAIT, with a simultaneous ack that reset must override.
      startOp(4'd3, 32'h300, 32'h0, 5'd1);
      checkOutput("rw_req", 32'(dc_req), 32'd1);
      rst    = 1'b1;
      dc_ack = 1'b1;
      #1;
      checkOutput("rw_stall", 32'(stall), 32'd0);
      tick();
      rst      = 1'b0;
      dc_ack   = 1'b0;
      ex_valid = 1'b0;
      checkOutput("rw_req_drop", 32'(dc_req), 32'd0);
      checkOutput("rw_wb_valid", 32'(wb_valid), 32'd0);

      startOp(4'd3, 32'h200, 32'h0, 5'd4);
      for (int j = 0; j < TO + 2; j++) begin
         checkOutput("to_flag", 32'(dc_timeout), (j >= TO) ? 32'd1 : 32'd0);
         tick();
      end
      finishOp(32'h0102_0304);
      checkOutput("to_wb_valid", 32'(wb_valid), 32'd1);
      checkOutput("to_wb_data", wb_data, 32'h0102_0304);
      checkOutput("to_sticky", 32'(dc_timeout), 32'd1);
      tick();
      checkOutput("to_sticky2", 32'(dc_timeout), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("to_clear", 32'(dc_timeout), 32'd0);

`ifdef MISALIGN_TRAP_EN
      applyStimulus(1'b1, 4'd3, 32'h101, 32'h0, 5'd8, 32'h0);
      #1;
      checkOutput("mis_stall", 32'(stall), 32'd0);
      tick();
      ex_valid = 1'b0;
      checkOutput("mis_flag", 32'(misalign), 32'd1);
      checkOutput("mis_req", 32'(dc_req), 32'd0);
      checkOutput("mis_wb_valid", 32'(wb_valid), 32'd0);
      tick();
      checkOutput("mis_pulse", 32'(misalign), 32'd0);
`else
      startOp(4'd3, 32'h101, 32'h0, 5'd8);
      checkOutput("unal_req", 32'(dc_req), 32'd1);
      checkOutput("unal_addr", dc_addr, 32'h100);
      finishOp(32'hA5A5_5A5A);
      checkOutput("unal_data", wb_data, 32'hA5A5_5A5A);
      startOp(4'd7, 32'h103, 32'h0000_BEEF, 5'd8);
      checkOutput("unal_sh_mask", 32'(dc_wmask), 32'h3);
      checkOutput("unal_sh_wdata", 32'(dc_wdata[15:0]), 32'h0000_BEEF);
      finishOp(32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
